nand_unit_arbiter: RTL

- Shares one WIDTH-bit bitwise NAND functional unit (OUT = ~(A & B)) between NUM_REQ requesters.
- Round-robin arbitration.
- Per-requester valid/ready request handshake; single registered response channel tagged with the requester ID.
- Sits between the CPU practice datapath clients (ALU ops, self-test sequencer) and the shared NAND logic, so only one NAND instance is built.

---
 rtl/nand_unit_arbiter_if.sv | 26 ++
 rtl/nand_unit_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/nand_unit_arbiter_if.sv
// Request/response bundle between the NAND arbiter and its clients.
// master: requester/consumer side; slave: the arbiter itself.
interface nand_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/nand_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise NAND unit between NUM_REQ clients.
// Flow: IDLE (grant + latch operands) -> EXEC (compute) -> RESP (hold until taken).
// Optional macro NAND_ARB_STATS_EN adds a saturating 16-bit op_count output.
module nand_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef NAND_ARB_STATS_EN
    output logic [15:0]        op_count,
`endif
    nand_unit_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;

    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_rr_next;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_found;
    logic               w_accept;

    // Round-robin search: first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        int                idx;
        logic [IDX_W-1:0]  w_idx;
        // NOTE: every output of a combinational block gets a default first so no path leaves it holding a value (latch).
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        idx      = 0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(r_rr_ptr) + k) % NUM_REQ;
            w_idx = IDX_W'(idx);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_gnt_id     = ID_W'(idx);
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_a = bus.req_a[k*WIDTH +: WIDTH];
                w_sel_b = bus.req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is asserted.
    assign w_ready       = (r_state == ST_IDLE && !rst) ? w_gnt : '0;
    assign w_accept      = |(bus.req_valid & w_ready);
    assign w_rr_next     = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Operand latch, round-robin pointer and registered response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_gnt_id <= w_gnt_id;
                r_rr_ptr <= w_rr_next;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data  <= ~(r_a & r_b);
                r_rsp_id    <= r_gnt_id;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == ST_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef NAND_ARB_STATS_EN
    logic [15:0] r_op_count;

    // Saturating count of consumed responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_rsp_valid && bus.rsp_ready && r_op_count != 16'hFFFF) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif
endmodule
